crf_node_sram_ctrl: RTL and testbench

- Initiator/controller for the CRF node-score SRAM (single-port, CE/WE-strobed, combinational read, high-Z output when disabled).
- Accepts write requests from the emission-score loader and read requests from the Viterbi stage over valid/ready handshakes.
- Serialises the requests onto the SRAM cellEnable/writeEnable/nodeIndex/inData pins and returns read data with a one-cycle valid pulse.

---
 rtl/crf_node_sram_ctrl_if.sv | 67 ++++++
 rtl/crf_node_sram_ctrl.sv | 174 +++++++++++++++++
 tb/tb_crf_node_sram_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/crf_node_sram_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : crf_node_sram_ctrl_if
// Purpose  : Bundles the request/response handshakes and the SRAM pin bus of
//            the CRF node-score SRAM controller.
// Ports    : write request   (wr_valid/wr_ready/wr_index/wr_data)
//            read request    (rd_req_valid/rd_req_ready/rd_index)
//            read response   (rd_data_valid/rd_data)
//            SRAM pins       (sram_in_data/sram_node_index/sram_cell_enable/
//                             sram_write_enable/sram_out_data)
//            status          (busy)
// Modports : slave  - the controller (answers requests, drives SRAM pins)
//            master - the environment (requesters and the SRAM macro)
// Revision : 1.0 - initial release
// ============================================================================
interface crf_node_sram_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);

  // Write request channel (emission-score loader)
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_index;
  logic [DATA_WIDTH-1:0] wr_data;

  // Read request channel (Viterbi stage)
  logic                  rd_req_valid;
  logic                  rd_req_ready;
  logic [ADDR_WIDTH-1:0] rd_index;

  // Read response
  logic                  rd_data_valid;
  logic [DATA_WIDTH-1:0] rd_data;

  // SRAM pins
  logic [DATA_WIDTH-1:0] sram_in_data;
  logic [ADDR_WIDTH-1:0] sram_node_index;
  logic                  sram_cell_enable;
  logic                  sram_write_enable;
  logic [DATA_WIDTH-1:0] sram_out_data;

  // Status
  logic                  busy;

  modport slave (
    input  wr_valid, wr_index, wr_data,
    input  rd_req_valid, rd_index,
    input  sram_out_data,
    output wr_ready, rd_req_ready,
    output rd_data_valid, rd_data,
    output sram_in_data, sram_node_index, sram_cell_enable, sram_write_enable,
    output busy
  );

  modport master (
    output wr_valid, wr_index, wr_data,
    output rd_req_valid, rd_index,
    output sram_out_data,
    input  wr_ready, rd_req_ready,
    input  rd_data_valid, rd_data,
    input  sram_in_data, sram_node_index, sram_cell_enable, sram_write_enable,
    input  busy
  );

endinterface
`default_nettype wire

// File: rtl/crf_node_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : crf_node_sram_ctrl
// Purpose  : Controller for the single-port CRF node-score SRAM. Serialises
//            write requests (loader) and read requests (Viterbi stage) onto
//            the CE/WE-strobed SRAM pins and returns read words with a
//            one-cycle valid pulse. Writes win over reads when both are
//            pending in the same idle cycle.
// Ports    : clk     - system clock, rising edge
//            reset   - synchronous, active-high reset
//            ctrl_if - request/response handshakes and SRAM pins
//                      (crf_node_sram_ctrl_if, slave side)
// Timing   : write = WRITE_CYCLES+1 cycles (accept + CE/WE hold)
//            read  = 3 cycles (accept, READ strobe, RESP valid pulse)
// Revision : 1.0 - initial release
// ============================================================================
module crf_node_sram_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 4,
  parameter int WRITE_CYCLES = 2    // CE/WE hold length, 1..15
) (
  input  logic                clk,
  input  logic                reset,
  crf_node_sram_ctrl_if.slave ctrl_if
);

  // Four bits cover the full 1..15 WRITE_CYCLES range.
  localparam int                CNT_W     = 4;
  localparam logic [CNT_W-1:0] C_WR_LAST = CNT_W'(WRITE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  ce_q, ce_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  idle;
  logic                  wr_ready;
  logic                  rd_ready;
  logic                  wr_fire;
  logic                  rd_fire;

  // --------------------------------------------------------------------------
  // Handshakes. Readiness is gated by reset so nothing is accepted while the
  // block is being reset. A pending write masks read readiness, which is how
  // the write wins arbitration without dropping the read: the requester keeps
  // rd_req_valid high and is served at the next idle edge.
  // --------------------------------------------------------------------------
  assign idle     = (state_q == S_IDLE);
  assign wr_ready = idle & ~reset;
  assign rd_ready = idle & ~ctrl_if.wr_valid & ~reset;
  assign wr_fire  = ctrl_if.wr_valid & wr_ready;
  assign rd_fire  = ctrl_if.rd_req_valid & rd_ready;

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ce_q     <= 1'b0;
      we_q     <= 1'b0;
      idx_q    <= '0;
      din_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ce_q     <= ce_d;
      we_q     <= we_d;
      idx_q    <= idx_d;
      din_q    <= din_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      cnt_q    <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and registered-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    // Hold everything by default; the valid pulse is the only thing that
    // self-clears.
    state_d  = state_q;
    ce_d     = ce_q;
    we_d     = we_q;
    idx_d    = idx_q;
    din_d    = din_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    cnt_d    = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        // Index and data pins keep their last values while idle; only the
        // strobes are low, which leaves the SRAM output high-Z.
        ce_d = 1'b0;
        we_d = 1'b0;
        if (wr_fire) begin
          state_d = S_WRITE;
          idx_d   = ctrl_if.wr_index;
          din_d   = ctrl_if.wr_data;
          ce_d    = 1'b1;
          we_d    = 1'b1;
          cnt_d   = C_WR_LAST;
        end else if (rd_fire) begin
          state_d = S_READ;
          idx_d   = ctrl_if.rd_index;
          ce_d    = 1'b1;
          we_d    = 1'b0;
        end
      end

      S_WRITE: begin
        // Counter is loaded with WRITE_CYCLES-1 at acceptance, so leaving on
        // the zero edge gives exactly WRITE_CYCLES strobe cycles.
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          ce_d    = 1'b0;
          we_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_READ: begin
        // The SRAM read path is combinational, so the word is already on
        // sram_out_data during the single CE cycle.
        state_d  = S_RESP;
        rdata_d  = ctrl_if.sram_out_data;
        rvalid_d = 1'b1;
        ce_d     = 1'b0;
        we_d     = 1'b0;
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        ce_d    = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign ctrl_if.wr_ready          = wr_ready;
  assign ctrl_if.rd_req_ready      = rd_ready;
  assign ctrl_if.rd_data_valid     = rvalid_q;
  assign ctrl_if.rd_data           = rdata_q;
  assign ctrl_if.sram_in_data      = din_q;
  assign ctrl_if.sram_node_index   = idx_q;
  assign ctrl_if.sram_cell_enable  = ce_q;
  assign ctrl_if.sram_write_enable = we_q;
  assign ctrl_if.busy              = ~idle;

endmodule
`default_nettype wire

// File: tb/tb_crf_node_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_crf_node_sram_ctrl
// Purpose  : Self-checking bench for crf_node_sram_ctrl. A transaction-level
//            reference (operation kind + age in cycles + golden memory)
//            predicts every output each cycle; directed scenarios add literal
//            expectations on top.
// Revision : 1.0 - initial release
// ============================================================================
module tb_crf_node_sram_ctrl;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int WC = 2;
  localparam int NN = 16;

  logic clk;
  logic reset;

  crf_node_sram_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  crf_node_sram_ctrl #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .WRITE_CYCLES(WC)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .ctrl_if(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // --------------------------------------------------------------------------
  // SRAM macro model: write on a clock edge with CE&WE, combinational read.
  // The disabled (high-Z) output is shown as zero in two-state simulation.
  // --------------------------------------------------------------------------
  bit [DW-1:0] sram_mem [NN];

  always_comb begin
    bus.sram_out_data = '0;
    if (bus.sram_cell_enable) bus.sram_out_data = sram_mem[bus.sram_node_index];
  end

  // --------------------------------------------------------------------------
  // Edge sampler: inputs seen by the DUT at each rising edge
  // --------------------------------------------------------------------------
  bit          smp_valid;
  bit          smp_reset;
  bit          smp_wr_valid, smp_rd_valid;
  bit          smp_wr_fire,  smp_rd_fire;
  bit [AW-1:0] smp_wr_idx,   smp_rd_idx;
  bit [DW-1:0] smp_wr_data;
  int          cyc = 0;

  always @(posedge clk) begin
    cyc          <= cyc + 1;
    smp_valid    <= 1'b1;
    smp_reset    <= reset;
    smp_wr_valid <= bus.wr_valid;
    smp_rd_valid <= bus.rd_req_valid;
    smp_wr_idx   <= bus.wr_index;
    smp_wr_data  <= bus.wr_data;
    smp_rd_idx   <= bus.rd_index;
    smp_wr_fire  <= bus.wr_valid & bus.wr_ready;
    smp_rd_fire  <= bus.rd_req_valid & bus.rd_req_ready;
    if (bus.sram_cell_enable && bus.sram_write_enable)
      sram_mem[bus.sram_node_index] <= bus.sram_in_data;
  end

  // --------------------------------------------------------------------------
  // Check helpers
  // --------------------------------------------------------------------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s at %0t: got timeout expected handshake/response", name, $time);
  endtask

  // --------------------------------------------------------------------------
  // Reference model: what is in flight (none / write / read), how many cycles
  // since it was accepted, and what the memory should contain.
  // --------------------------------------------------------------------------
  localparam int OP_NONE = 0;
  localparam int OP_WR   = 1;
  localparam int OP_RD   = 2;

  int          m_op  = OP_NONE;
  int          m_age = 0;
  bit [AW-1:0] e_idx = '0;
  bit [DW-1:0] e_din = '0;
  bit [DW-1:0] e_rd  = '0;
  bit          e_rd_known = 1'b1;
  bit [DW-1:0] gold [NN];
  bit          gold_known [NN];

  task automatic step_model();
    bit wr_acc, rd_acc;
    if (smp_reset) begin
      if (m_op == OP_WR) gold_known[e_idx] = 1'b0;  // interrupted write
      m_op = OP_NONE; m_age = 0;
      e_idx = '0; e_din = '0; e_rd = '0; e_rd_known = 1'b1;
    end else if (m_op == OP_NONE) begin
      wr_acc = smp_wr_valid;
      rd_acc = smp_rd_valid && !smp_wr_valid;
      if (wr_acc) begin
        m_op = OP_WR; m_age = 1;
        e_idx = smp_wr_idx; e_din = smp_wr_data;
        gold[smp_wr_idx] = smp_wr_data;
        gold_known[smp_wr_idx] = 1'b1;
      end else if (rd_acc) begin
        m_op = OP_RD; m_age = 1;
        e_idx = smp_rd_idx;
      end
    end else if (m_op == OP_WR) begin
      m_age++;
      if (m_age > WC) m_op = OP_NONE;
    end else begin
      m_age++;
      if (m_age == 2) begin
        e_rd = gold[e_idx];
        e_rd_known = gold_known[e_idx];
      end else begin
        m_op = OP_NONE;
      end
    end
  endtask

  task automatic compare_outputs();
    bit idle_now;
    idle_now = (m_op == OP_NONE);
    chk("ce",        32'(bus.sram_cell_enable),  32'((m_op == OP_WR) || (m_op == OP_RD && m_age == 1)));
    chk("we",        32'(bus.sram_write_enable), 32'(m_op == OP_WR));
    chk("node_idx",  32'(bus.sram_node_index),   32'(e_idx));
    chk("in_data",   bus.sram_in_data,           e_din);
    chk("rd_valid",  32'(bus.rd_data_valid),     32'(m_op == OP_RD && m_age == 2));
    chk("busy",      32'(bus.busy),              32'(!idle_now));
    chk("wr_ready",  32'(bus.wr_ready),          32'(idle_now && !reset));
    chk("rd_ready",  32'(bus.rd_req_ready),      32'(idle_now && !reset && !bus.wr_valid));
    if (e_rd_known) chk("rd_data", bus.rd_data, e_rd);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (smp_valid) begin
        step_model();
        compare_outputs();
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus tasks (inputs change 1 time unit after a rising edge)
  // --------------------------------------------------------------------------
  task automatic do_write(input logic [AW-1:0] idx, input logic [DW-1:0] data, output int fire_cyc);
    int n;
    bus.wr_valid = 1'b1;
    bus.wr_index = idx;
    bus.wr_data  = data;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!smp_wr_fire && n < 20);
    if (!smp_wr_fire) fail_now("wr_handshake_timeout");
    fire_cyc     = cyc;
    bus.wr_valid = 1'b0;
  endtask

  task automatic wait_rd_valid(output logic [DW-1:0] data, output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.rd_data_valid && lat < 10);
    if (!bus.rd_data_valid) fail_now("rd_valid_timeout");
    data = bus.rd_data;
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [AW-1:0] idx, output logic [DW-1:0] data,
                         output int lat, output int fire_cyc);
    int n;
    bus.rd_req_valid = 1'b1;
    bus.rd_index     = idx;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!smp_rd_fire && n < 20);
    if (!smp_rd_fire) fail_now("rd_handshake_timeout");
    fire_cyc         = cyc;
    bus.rd_req_valid = 1'b0;
    wait_rd_valid(data, lat);
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    logic [DW-1:0] d;
    int lat, fc, prev, wfc, n, cnt;

    reset            = 1'b1;
    bus.wr_valid     = 1'b0;
    bus.wr_index     = '0;
    bus.wr_data      = '0;
    bus.rd_req_valid = 1'b0;
    bus.rd_index     = '0;

    // Reset held two cycles
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ce",       32'(bus.sram_cell_enable),  32'd0);
    chk("rst_we",       32'(bus.sram_write_enable), 32'd0);
    chk("rst_wr_ready", 32'(bus.wr_ready),          32'd1);
    chk("rst_rd_ready", 32'(bus.rd_req_ready),      32'd1);
    chk("rst_rd_data",  bus.rd_data,                32'd0);
    chk("rst_rd_valid", 32'(bus.rd_data_valid),     32'd0);
    chk("rst_busy",     32'(bus.busy),              32'd0);
    chk("rst_out_bus",  bus.sram_out_data,          32'd0);
    @(posedge clk); #1;

    // Single write then read of index 1
    do_write(4'd1, 32'hFFFF_FFFF, fc);
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.sram_cell_enable && bus.sram_write_enable && bus.sram_node_index == 4'd1) cnt++;
    end
    chk("wr_strobe_cycles", 32'(cnt), 32'd2);
    @(posedge clk); #1;
    do_read(4'd1, d, lat, fc);
    chk("rd_idx1_data", d, 32'hFFFF_FFFF);
    chk("rd_latency", 32'(lat), 32'd2);

    // Simultaneous write and read of index 3: write first
    bus.wr_valid     = 1'b1;
    bus.wr_index     = 4'd3;
    bus.wr_data      = 32'h1234_5678;
    bus.rd_req_valid = 1'b1;
    bus.rd_index     = 4'd3;
    @(negedge clk);
    chk("conflict_rd_ready", 32'(bus.rd_req_ready), 32'd0);
    chk("conflict_wr_ready", 32'(bus.wr_ready),     32'd1);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!smp_wr_fire && n < 20);
    if (!smp_wr_fire) fail_now("conflict_wr_timeout");
    chk("conflict_rd_not_first", 32'(smp_rd_fire), 32'd0);
    wfc = cyc;
    bus.wr_valid = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!smp_rd_fire && n < 20);
    if (!smp_rd_fire) fail_now("conflict_rd_timeout");
    chk("conflict_rd_accept_gap", 32'(cyc - wfc), 32'd3);
    bus.rd_req_valid = 1'b0;
    wait_rd_valid(d, lat);
    chk("conflict_data", d, 32'h1234_5678);

    // Sweep all indices back-to-back
    prev = 0;
    for (int i = 0; i < NN; i++) begin
      do_write(AW'(i), 32'h100 + 32'(i), fc);
      if (i > 0) chk($sformatf("sweep_wr_gap%0d", i), 32'(fc - prev), 32'd3);
      prev = fc;
    end
    for (int i = 0; i < NN; i++) begin
      do_read(AW'(i), d, lat, fc);
      chk($sformatf("sweep_rd_data%0d", i), d, 32'h100 + 32'(i));
      if (i > 0) chk($sformatf("sweep_rd_gap%0d", i), 32'(fc - prev), 32'd3);
      prev = fc;
    end

    // Reset during the second WRITE cycle
    do_write(4'd5, 32'hA5A5_A5A5, fc);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("midwr_ce",       32'(bus.sram_cell_enable),  32'd0);
    chk("midwr_we",       32'(bus.sram_write_enable), 32'd0);
    chk("midwr_busy",     32'(bus.busy),              32'd0);
    chk("midwr_wr_ready", 32'(bus.wr_ready),          32'd1);
    @(posedge clk); #1;
    do_write(4'd5, 32'h5A5A_0FF0, fc);
    do_read(4'd5, d, lat, fc);
    chk("midwr_reread", d, 32'h5A5A_0FF0);

    // Reset during the READ cycle
    do_write(4'd7, 32'hDEAD_BEEF, fc);
    bus.rd_req_valid = 1'b1;
    bus.rd_index     = 4'd7;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!smp_rd_fire && n < 20);
    if (!smp_rd_fire) fail_now("midrd_handshake_timeout");
    bus.rd_req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.rd_data_valid) cnt++;
    end
    chk("midrd_no_pulse", 32'(cnt),      32'd0);
    chk("midrd_rd_data",  bus.rd_data,   32'd0);
    chk("midrd_busy",     32'(bus.busy), 32'd0);
    @(posedge clk); #1;

    // Randomised traffic with occasional resets; the model checks every cycle
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 49) == 0) reset = 1'b1;
      if (smp_wr_fire) bus.wr_valid = 1'b0;
      if (smp_rd_fire) bus.rd_req_valid = 1'b0;
      if (!bus.wr_valid && $urandom_range(0, 3) == 0) begin
        bus.wr_valid = 1'b1;
        bus.wr_index = AW'($urandom_range(0, NN - 1));
        bus.wr_data  = $urandom;
      end
      if (!bus.rd_req_valid && $urandom_range(0, 2) == 0) begin
        bus.rd_req_valid = 1'b1;
        bus.rd_index     = AW'($urandom_range(0, NN - 1));
      end
    end
    reset = 1'b0;
    n = 0;
    while ((bus.wr_valid || bus.rd_req_valid) && n < 60) begin
      @(posedge clk); #1; n++;
      if (smp_wr_fire) bus.wr_valid = 1'b0;
      if (smp_rd_fire) bus.rd_req_valid = 1'b0;
    end
    if (bus.wr_valid || bus.rd_req_valid) fail_now("drain_timeout");
    bus.wr_valid     = 1'b0;
    bus.rd_req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
